// File: rtl/ps2_scancode_decoder.sv
// rtl/ps2_scancode_decoder.sv - PS/2 scan code set 2 byte stream to key events
//
// Pops raw keyboard bytes from the PS/2 receiver FIFO, folds the E0/F0/E1
// prefixes into single key events and keeps held levels for the three
// pinball control keys.
//
// Optional build macro: TYPEMATIC_FILTER_EN - suppress auto-repeat makes of
// the most recently pressed key until any break is seen.
//
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   fifo_data      head byte of receiver FIFO (valid while fifo_empty=0)
//   fifo_empty     receiver FIFO empty
//   fifo_overflow  receiver overflow flag (cleared by the receiver on read)
//   fifo_rd        read strobe, pops the head byte at the end of the cycle
//   key_valid      one-cycle event pulse for key_code/key_ext/key_break
//   key_code       event scan code (8'hE1 for pause)
//   key_ext        event carried an E0 prefix
//   key_break      1 = release, 0 = press
//   flip_left      LEFT_CODE held
//   flip_right     RIGHT_CODE held
//   launch         LAUNCH_CODE held
//   sync_err       one-cycle pulse on overflow or illegal prefix sequence

module ps2_scancode_decoder #(
  parameter logic [7:0] LEFT_CODE   = 8'h12,
  parameter logic [7:0] RIGHT_CODE  = 8'h59,
  parameter logic [7:0] LAUNCH_CODE = 8'h29,
  parameter int         PAUSE_LEN   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  input  logic       fifo_overflow,
  output logic       fifo_rd,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       flip_left,
  output logic       flip_right,
  output logic       launch,
  output logic       sync_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_E0    = 3'd1;
  localparam logic [2:0] S_F0    = 3'd2;
  localparam logic [2:0] S_E0F0  = 3'd3;
  localparam logic [2:0] S_PAUSE = 3'd4;

  localparam logic [7:0] PAUSE_INIT = 8'(PAUSE_LEN - 1);

  logic [2:0] state, state_n;
  logic [7:0] pause_cnt, pause_cnt_n;
  logic       ev, ev_ext, ev_brk, err, ovf_hit, suppress, fire;
  logic [7:0] ev_code;

  // Keyboard-to-host controller responses carry no key information.
  function automatic logic is_resp(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_resp = 1'b1;
      default:                                         is_resp = 1'b0;
    endcase
  endfunction

  assign fifo_rd = ~fifo_empty & ~reset;
  assign ovf_hit = fifo_rd & fifo_overflow;

  always_comb begin
    state_n     = state;
    pause_cnt_n = pause_cnt;
    ev          = 1'b0;
    ev_code     = fifo_data;
    ev_ext      = 1'b0;
    ev_brk      = 1'b0;
    err         = 1'b0;
    if (ovf_hit) begin
      // Byte is untrustworthy: drop it and resynchronise from IDLE.
      state_n     = S_IDLE;
      pause_cnt_n = 8'd0;
      err         = 1'b1;
    end else if (fifo_rd) begin
      case (state)
        S_IDLE: begin
          if (fifo_data == 8'hE0) begin
            state_n = S_E0;
          end else if (fifo_data == 8'hF0) begin
            state_n = S_F0;
          end else if (fifo_data == 8'hE1) begin
            if (PAUSE_LEN <= 1) begin
              ev = 1'b1;
            end else begin
              state_n     = S_PAUSE;
              pause_cnt_n = PAUSE_INIT;
            end
          end else if (!is_resp(fifo_data)) begin
            ev = 1'b1;
          end
        end
        S_E0: begin
          state_n = S_IDLE;
          if (fifo_data == 8'hF0) begin
            state_n = S_E0F0;
          end else if (fifo_data == 8'hE0) begin
            state_n = S_E0;
          end else if (fifo_data == 8'hE1) begin
            err = 1'b1;
          end else if (fifo_data != 8'h12) begin
            ev     = 1'b1;
            ev_ext = 1'b1;
          end
        end
        S_F0: begin
          state_n = S_IDLE;
          if (fifo_data == 8'hE0 || fifo_data == 8'hF0 || fifo_data == 8'hE1) begin
            err = 1'b1;
          end else begin
            ev     = 1'b1;
            ev_brk = 1'b1;
          end
        end
        S_E0F0: begin
          state_n = S_IDLE;
          if (fifo_data == 8'hE0 || fifo_data == 8'hF0 || fifo_data == 8'hE1) begin
            err = 1'b1;
          end else if (fifo_data != 8'h12) begin
            ev     = 1'b1;
            ev_ext = 1'b1;
            ev_brk = 1'b1;
          end
        end
        S_PAUSE: begin
          // Pause body bytes are counted, never decoded.
          pause_cnt_n = pause_cnt - 8'd1;
          if (pause_cnt == 8'd1) begin
            state_n = S_IDLE;
            ev      = 1'b1;
            ev_code = 8'hE1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

`ifdef TYPEMATIC_FILTER_EN
  logic       trk_valid;
  logic [8:0] trk_key;
  logic       ev_is_pause;

  // Only pause can produce an event whose code is E1.
  assign ev_is_pause = (ev_code == 8'hE1);
  assign suppress    = ev & ~ev_brk & ~ev_is_pause & trk_valid &
                       (trk_key == {ev_ext, ev_code});

  always_ff @(posedge clk) begin
    if (reset || ovf_hit) begin
      trk_valid <= 1'b0;
      trk_key   <= 9'd0;
    end else if (ev && ev_brk) begin
      trk_valid <= 1'b0;
    end else if (ev && !ev_is_pause) begin
      trk_valid <= 1'b1;
      trk_key   <= {ev_ext, ev_code};
    end
  end
`else
  assign suppress = 1'b0;
`endif

  assign fire = ev & ~suppress;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      pause_cnt  <= 8'd0;
      key_valid  <= 1'b0;
      key_code   <= 8'd0;
      key_ext    <= 1'b0;
      key_break  <= 1'b0;
      flip_left  <= 1'b0;
      flip_right <= 1'b0;
      launch     <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state     <= state_n;
      pause_cnt <= pause_cnt_n;
      key_valid <= fire;
      sync_err  <= err;
      if (fire) begin
        key_code  <= ev_code;
        key_ext   <= ev_ext;
        key_break <= ev_brk;
      end
      if (ovf_hit) begin
        flip_left  <= 1'b0;
        flip_right <= 1'b0;
        launch     <= 1'b0;
      end else if (fire && !ev_ext) begin
        if (ev_code == LEFT_CODE)   flip_left  <= ~ev_brk;
        if (ev_code == RIGHT_CODE)  flip_right <= ~ev_brk;
        if (ev_code == LAUNCH_CODE) launch     <= ~ev_brk;
      end
    end
  end

endmodule
